// File: rtl/move_arbiter.sv
// move_arbiter: resolves piece moves against the board, locks pieces, spawn game-over check.
// Optional LOCK_COUNTER_EN builds a saturating pieces_locked counter.
module move_arbiter #(
    parameter int V_COLS    = 10,
    parameter int H_ROWS    = 20,
    parameter int SPAWN_DLY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        movement_request,
    input  logic        movement_intent,
    input  logic [4:0]  P1blk_v,
    input  logic [4:0]  P2blk_v,
    input  logic [4:0]  P3blk_v,
    input  logic [4:0]  P4blk_v,
    input  logic [4:0]  P1blk_h,
    input  logic [4:0]  P2blk_h,
    input  logic [4:0]  P3blk_h,
    input  logic [4:0]  P4blk_h,
    input  logic [2:0]  volatile_blk_color,
    output logic        movement_commit,
    output logic        movement_declined,
    output logic        movement_steal,
    output logic [4:0]  rd_v,
    output logic [4:0]  rd_h,
    input  logic        rd_occ,
    output logic        wr_en,
    output logic [4:0]  wr_v,
    output logic [4:0]  wr_h,
    output logic [2:0]  wr_color,
    output logic        lock_done,
    output logic        game_over,
    output logic [15:0] pieces_locked
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_DECIDE,
        S_COMMIT,
        S_DECLINE,
        S_LOCK,
        S_LOCK_DONE,
        S_HOLD,
        S_SPAWN_WAIT,
        S_SPAWN_CHK,
        S_SPAWN_END
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [7:0] dly_cnt;
    logic [4:0] in_v  [4];
    logic [4:0] in_h  [4];
    logic [4:0] lat_v [4];
    logic [4:0] lat_h [4];
    logic [4:0] com_v [4];
    logic [4:0] com_h [4];
    logic       intent_q;
    logic       collide;
    logic       game_over_q;
    logic [1:0] sidx;
    logic       sampling;
    logic       hit;
    logic       collide_f;
    logic       dly_last;

    always_comb begin
        in_v[0] = P1blk_v;
        in_v[1] = P2blk_v;
        in_v[2] = P3blk_v;
        in_v[3] = P4blk_v;
        in_h[0] = P1blk_h;
        in_h[1] = P2blk_h;
        in_h[2] = P3blk_h;
        in_h[3] = P4blk_h;
    end

    // rd_occ answers the address issued one cycle earlier, so it belongs to block cnt-1
    always_comb begin
        sidx      = cnt - 2'd1;
        sampling  = ((state == S_CHECK || state == S_SPAWN_CHK) && cnt != 2'd0)
                    || state == S_DECIDE || state == S_SPAWN_END;
        hit       = rd_occ
                    || (lat_v[sidx] >= 5'(V_COLS))
                    || (lat_h[sidx] >= 5'(H_ROWS));
        collide_f = collide | hit;
        dly_last  = (dly_cnt == 8'(SPAWN_DLY - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (movement_request) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (cnt == 2'd3) state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                if (game_over_q)     state_nxt = S_DECLINE;
                else if (!collide_f) state_nxt = S_COMMIT;
                else if (intent_q)   state_nxt = S_DECLINE;
                else                 state_nxt = S_LOCK;
            end
            S_COMMIT, S_DECLINE: begin
                if (!movement_request) state_nxt = S_IDLE;
            end
            S_LOCK: begin
                if (cnt == 2'd3) state_nxt = S_LOCK_DONE;
            end
            S_LOCK_DONE: begin
                state_nxt = movement_request ? S_HOLD : S_SPAWN_WAIT;
            end
            S_HOLD: begin
                if (!movement_request) state_nxt = S_SPAWN_WAIT;
            end
            S_SPAWN_WAIT: begin
                if (dly_last) state_nxt = S_SPAWN_CHK;
            end
            S_SPAWN_CHK: begin
                if (cnt == 2'd3) state_nxt = S_SPAWN_END;
            end
            S_SPAWN_END: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        movement_commit   = (state == S_COMMIT);
        movement_declined = (state == S_DECLINE);
        movement_steal    = (state == S_LOCK) || (state == S_LOCK_DONE)
                            || (state == S_HOLD);
        lock_done         = (state == S_LOCK_DONE);
        game_over         = game_over_q;
        rd_v              = 5'd0;
        rd_h              = 5'd0;
        wr_en             = 1'b0;
        wr_v              = 5'd0;
        wr_h              = 5'd0;
        wr_color          = 3'd0;
        if (state == S_CHECK || state == S_SPAWN_CHK) begin
            rd_v = lat_v[cnt];
            rd_h = lat_h[cnt];
        end
        if (state == S_LOCK) begin
            wr_en    = 1'b1;
            wr_v     = com_v[cnt];
            wr_h     = com_h[cnt];
            wr_color = volatile_blk_color;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 2'd0;
            dly_cnt <= 8'd0;
        end else begin
            if (state == S_CHECK || state == S_SPAWN_CHK || state == S_LOCK) begin
                cnt <= cnt + 2'd1;
            end else begin
                cnt <= 2'd0;
            end
            if (state == S_SPAWN_WAIT) begin
                dly_cnt <= dly_cnt + 8'd1;
            end else begin
                dly_cnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                lat_v[i] <= 5'd0;
                lat_h[i] <= 5'd0;
                com_v[i] <= 5'd0;
                com_h[i] <= 5'd0;
            end
            intent_q    <= 1'b0;
            collide     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            if (state == S_IDLE && movement_request) begin
                for (int i = 0; i < 4; i++) begin
                    lat_v[i] <= in_v[i];
                    lat_h[i] <= in_h[i];
                end
                intent_q <= movement_intent;
                collide  <= 1'b0;
            end else if (sampling) begin
                collide <= collide_f;
            end
            // new piece becomes both the check target and the last accepted position
            if (state == S_SPAWN_WAIT && dly_last) begin
                for (int i = 0; i < 4; i++) begin
                    lat_v[i] <= in_v[i];
                    lat_h[i] <= in_h[i];
                    com_v[i] <= in_v[i];
                    com_h[i] <= in_h[i];
                end
                collide <= 1'b0;
            end
            if (state == S_DECIDE && !game_over_q && !collide_f) begin
                for (int i = 0; i < 4; i++) begin
                    com_v[i] <= lat_v[i];
                    com_h[i] <= lat_h[i];
                end
            end
            if (state == S_SPAWN_END && collide_f) begin
                game_over_q <= 1'b1;
            end
        end
    end

`ifdef LOCK_COUNTER_EN
    logic [15:0] lock_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= 16'd0;
        end else if (state == S_LOCK_DONE && lock_cnt != 16'hFFFF) begin
            lock_cnt <= lock_cnt + 16'd1;
        end
    end

    assign pieces_locked = lock_cnt;
`else
    assign pieces_locked = 16'd0;
`endif

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: table-driven moves with a write scoreboard and a board RAM model.
// Covers commit/decline/steal, bounds, game over and reset during lock.
module tb_move_arbiter;

    localparam logic [2:0] R_C = 3'b100;
    localparam logic [2:0] R_D = 3'b010;
    localparam logic [2:0] R_S = 3'b001;

    typedef struct {
        logic            intent;
        logic [3:0][4:0] v;
        logic [3:0][4:0] h;
        logic [2:0]      color;
        logic [2:0]      resp;
        logic [3:0][4:0] sv;
        logic [3:0][4:0] sh;
        logic            go;
    } vec_t;

    typedef struct packed {
        logic [4:0] v;
        logic [4:0] h;
        logic [2:0] c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        movement_request;
    logic        movement_intent;
    logic [4:0]  P1blk_v, P2blk_v, P3blk_v, P4blk_v;
    logic [4:0]  P1blk_h, P2blk_h, P3blk_h, P4blk_h;
    logic [2:0]  volatile_blk_color;
    logic        movement_commit;
    logic        movement_declined;
    logic        movement_steal;
    logic [4:0]  rd_v;
    logic [4:0]  rd_h;
    logic        rd_occ = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_v;
    logic [4:0]  wr_h;
    logic [2:0]  wr_color;
    logic        lock_done;
    logic        game_over;
    logic [15:0] pieces_locked;

    int total = 0;
    int bad = 0;
    wr_t exp_q[$];
    wr_t act_q[$];
    bit board [32][32];
    logic [3:0][4:0] exp_com_v;
    logic [3:0][4:0] exp_com_h;
    vec_t tbl [14];

    move_arbiter dut (
        .clk(clk),
        .reset(rst_n),
        .movement_request(movement_request),
        .movement_intent(movement_intent),
        .P1blk_v(P1blk_v),
        .P2blk_v(P2blk_v),
        .P3blk_v(P3blk_v),
        .P4blk_v(P4blk_v),
        .P1blk_h(P1blk_h),
        .P2blk_h(P2blk_h),
        .P3blk_h(P3blk_h),
        .P4blk_h(P4blk_h),
        .volatile_blk_color(volatile_blk_color),
        .movement_commit(movement_commit),
        .movement_declined(movement_declined),
        .movement_steal(movement_steal),
        .rd_v(rd_v),
        .rd_h(rd_h),
        .rd_occ(rd_occ),
        .wr_en(wr_en),
        .wr_v(wr_v),
        .wr_h(wr_h),
        .wr_color(wr_color),
        .lock_done(lock_done),
        .game_over(game_over),
        .pieces_locked(pieces_locked)
    );

    always #5 clk = ~clk;

    // board RAM: one-cycle read latency, cell (5,3) permanently occupied
    always @(posedge clk) begin
        rd_occ <= board[rd_v][rd_h] | (rd_v == 5'd5 && rd_h == 5'd3);
        if (wr_en) board[wr_v][wr_h] <= 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && wr_en) act_q.push_back('{v: wr_v, h: wr_h, c: wr_color});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][4:0] c4(input int a, input int b, input int c, input int d);
        logic [3:0][4:0] r;
        r[0] = 5'(a);
        r[1] = 5'(b);
        r[2] = 5'(c);
        r[3] = 5'(d);
        return r;
    endfunction

    function automatic vec_t mk(input logic in, input logic [3:0][4:0] v,
                                input logic [3:0][4:0] h, input logic [2:0] col,
                                input logic [2:0] rs, input logic [3:0][4:0] sv,
                                input logic [3:0][4:0] sh, input logic go);
        vec_t t;
        t.intent = in;
        t.v      = v;
        t.h      = h;
        t.color  = col;
        t.resp   = rs;
        t.sv     = sv;
        t.sh     = sh;
        t.go     = go;
        return t;
    endfunction

    task automatic set_p(input logic [3:0][4:0] v, input logic [3:0][4:0] h);
        P1blk_v = v[0]; P2blk_v = v[1]; P3blk_v = v[2]; P4blk_v = v[3];
        P1blk_h = h[0]; P2blk_h = h[1]; P3blk_h = h[2]; P4blk_h = h[3];
    endtask

    task automatic check_sb(input string nm);
        wr_t e;
        wr_t a;
        chk({nm, "_wrcount"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            chk({nm, "_wr"}, 32'(a), 32'(e));
        end
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic check_idle_outs(input string nm);
        chk({nm, "_commit"}, movement_commit, 0);
        chk({nm, "_declined"}, movement_declined, 0);
        chk({nm, "_steal"}, movement_steal, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_lock_done"}, lock_done, 0);
        chk({nm, "_rd"}, {rd_v, rd_h}, 0);
    endtask

    // raise a request and return the cycle index (after edge 0) of the first response
    task automatic issue(input vec_t t, output int lat);
        @(negedge clk);
        movement_intent    = t.intent;
        volatile_blk_color = t.color;
        set_p(t.v, t.h);
        movement_request   = 1'b1;
        if (t.resp == R_S) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back('{v: exp_com_v[i], h: exp_com_h[i], c: t.color});
        end
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (movement_commit | movement_declined | movement_steal) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        int lat;
        issue(t, lat);
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_resp"}, {movement_commit, movement_declined, movement_steal}, t.resp);
        if (t.resp == R_S) begin
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            chk({nm, "_lock_done"}, {lock_done, movement_steal, wr_en}, 3'b110);
            @(posedge clk);
            #1;
            chk({nm, "_steal_hold"}, {lock_done, movement_steal}, 2'b01);
            @(negedge clk);
            movement_request = 1'b0;
            set_p(t.sv, t.sh);
            @(posedge clk);
            #1;
            chk({nm, "_steal_drop"}, movement_steal, 0);
            exp_com_v = t.sv;
            exp_com_h = t.sh;
        end else begin
            @(posedge clk);
            #1;
            chk({nm, "_resp_hold"}, {movement_commit, movement_declined}, t.resp[2:1]);
            @(negedge clk);
            movement_request = 1'b0;
            @(posedge clk);
            #1;
            chk({nm, "_resp_drop"}, {movement_commit, movement_declined, movement_steal}, 0);
            if (t.resp == R_C) begin
                exp_com_v = t.v;
                exp_com_h = t.h;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        chk({nm, "_game_over"}, game_over, t.go);
        check_sb(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        movement_request = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_com_v = '0;
        exp_com_h = '0;
    endtask

    initial begin
        int lat;
        vec_t t;
        tbl[0]  = mk(0, c4(5, 6, 5, 6),   c4(1, 1, 2, 2),     3'd1, R_C, '0, '0, 0);
        tbl[1]  = mk(1, c4(31, 5, 31, 5), c4(1, 1, 2, 2),     3'd1, R_D, '0, '0, 0);
        tbl[2]  = mk(1, c4(6, 7, 6, 7),   c4(1, 1, 2, 2),     3'd1, R_C, '0, '0, 0);
        tbl[3]  = mk(1, c4(5, 6, 5, 6),   c4(2, 2, 3, 3),     3'd1, R_D, '0, '0, 0);
        tbl[4]  = mk(0, c4(6, 7, 6, 7),   c4(2, 2, 3, 3),     3'd1, R_C, '0, '0, 0);
        tbl[5]  = mk(1, c4(8, 9, 8, 9),   c4(3, 3, 4, 4),     3'd1, R_C, '0, '0, 0);
        tbl[6]  = mk(1, c4(9, 10, 9, 10), c4(3, 3, 4, 4),     3'd1, R_D, '0, '0, 0);
        tbl[7]  = mk(0, c4(8, 9, 8, 9),   c4(18, 18, 19, 19), 3'd4, R_C, '0, '0, 0);
        tbl[8]  = mk(1, c4(9, 10, 9, 10), c4(18, 18, 19, 19), 3'd4, R_D, '0, '0, 0);
        tbl[9]  = mk(0, c4(8, 9, 8, 9),   c4(19, 19, 20, 20), 3'b100, R_S,
                     c4(0, 1, 0, 1), c4(0, 0, 1, 1), 0);
        tbl[10] = mk(0, c4(31, 0, 31, 0), c4(0, 0, 1, 1),     3'b010, R_S,
                     c4(5, 6, 5, 6), c4(1, 1, 2, 2), 0);
        tbl[11] = mk(0, c4(5, 6, 5, 6),   c4(2, 2, 3, 3),     3'b001, R_S,
                     c4(5, 6, 5, 6), c4(1, 1, 2, 2), 1);
        tbl[12] = mk(0, c4(0, 1, 0, 1),   c4(10, 10, 11, 11), 3'd2, R_D, '0, '0, 1);
        tbl[13] = mk(0, c4(31, 0, 31, 0), c4(10, 10, 11, 11), 3'd2, R_D, '0, '0, 1);

        rst_n = 1'b0;
        movement_request = 1'b0;
        movement_intent = 1'b0;
        volatile_blk_color = 3'd0;
        set_p('0, '0);
        exp_com_v = '0;
        exp_com_h = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outs("in_reset");
        chk("in_reset_game_over", game_over, 0);
        chk("in_reset_pieces", pieces_locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outs("after_reset");

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

`ifdef LOCK_COUNTER_EN
        chk("pieces_locked_3", pieces_locked, 3);
`else
        chk("pieces_locked_off", pieces_locked, 0);
`endif

        do_reset();
        @(posedge clk);
        #1;
        chk("reset_clears_game_over", game_over, 0);
        chk("reset_clears_pieces", pieces_locked, 0);

        // lock aborted by reset during its second write
        run_vec(mk(0, c4(2, 3, 2, 3), c4(18, 18, 19, 19), 3'd3, R_C, '0, '0, 0), "pre_abort");
        t = mk(0, c4(2, 3, 2, 3), c4(19, 19, 20, 20), 3'b110, R_S, '0, '0, 0);
        exp_q.push_back('{v: 5'd2, h: 5'd18, c: 3'b110});
        @(negedge clk);
        movement_intent = t.intent;
        volatile_blk_color = t.color;
        set_p(t.v, t.h);
        movement_request = 1'b1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (movement_steal) begin
                lat = c;
                break;
            end
        end
        chk("abort_steal_latency", lat, 5);
        @(posedge clk);
        #1;
        chk("abort_second_write", {wr_en, wr_v, wr_h}, {1'b1, 5'd3, 5'd18});
        rst_n = 1'b0;
        #1;
        check_idle_outs("abort_reset");
        movement_request = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_sb("abort");
        chk("abort_game_over", game_over, 0);
        chk("abort_pieces", pieces_locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
